// File: rtl/tile_fetch_sequencer.sv
// rtl/tile_fetch_sequencer.sv - per-scanline tilemap fetch sequencer with token FIFO; optional stall counter under TILE_FETCH_STALL_STATS_EN
module tile_fetch_sequencer #(
    parameter int MAP_W      = 40,
    parameter int MAP_H      = 30,
    parameter int TILE_SHIFT = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_line_start,
    input  logic [9:0]  i_line_y,
    input  logic [5:0]  i_scroll_x,
    input  logic [5:0]  i_scroll_y,
    output logic [5:0]  o_tilemap_x_idx,
    output logic [5:0]  o_tilemap_y_idx,
    input  logic [7:0]  i_tilemap_texture_idx,
    output logic        o_tile_valid,
    input  logic        i_tile_ready,
    output logic [5:0]  o_tile_col,
    output logic [7:0]  o_tile_texture_idx,
    output logic        o_busy,
    output logic        o_overrun,
    output logic [15:0] o_stall_cycles
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [5:0]       LAST_COL  = 6'(MAP_W - 1);
    localparam logic [6:0]       MAP_H_W   = 7'(MAP_H);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_SPACE,
        S_CAPTURE
    } state_t;

    state_t state, state_nx;

    logic [5:0]       row;
    logic [5:0]       col_src;
    logic [5:0]       scr_col;
    logic [6:0]       row_sum;
    logic [5:0]       row_new;
    logic             overrun;

    logic [13:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_has_space;
    logic             push;
    logic             pop;
    logic             advance;
    logic             restart;

    // Sum stays below 2*MAP_H for legal inputs, so one conditional subtract wraps it.
    assign row_sum = 7'(i_line_y >> TILE_SHIFT) + 7'(i_scroll_y);
    assign row_new = (row_sum >= MAP_H_W) ? 6'(row_sum - MAP_H_W) : row_sum[5:0];

    assign fifo_has_space = (count != CNT_FULL);
    assign o_tile_valid   = (count != '0);
    assign pop            = o_tile_valid && i_tile_ready;
    assign restart        = i_line_start && (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        advance  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_line_start) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                state_nx = fifo_has_space ? S_CAPTURE : S_WAIT_SPACE;
            end
            S_WAIT_SPACE: begin
                if (fifo_has_space) state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                push = 1'b1;
                if (scr_col == LAST_COL) begin
                    state_nx = S_IDLE;
                end else begin
                    advance  = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (i_line_start) begin
            state_nx = S_ISSUE;
            advance  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row     <= '0;
            col_src <= '0;
            scr_col <= '0;
            overrun <= 1'b0;
        end else if (i_line_start) begin
            row     <= row_new;
            col_src <= i_scroll_x;
            scr_col <= '0;
            if (state != S_IDLE) overrun <= 1'b1;
        end else if (advance) begin
            col_src <= (col_src == LAST_COL) ? 6'd0 : col_src + 6'd1;
            scr_col <= scr_col + 6'd1;
        end
    end

    // A restart discards both the stale queue and the capture in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (restart) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {scr_col, i_tilemap_texture_idx};
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign {o_tile_col, o_tile_texture_idx} = fifo_mem[rd_ptr];
    assign o_tilemap_x_idx = col_src;
    assign o_tilemap_y_idx = row;
    assign o_busy          = (state != S_IDLE);
    assign o_overrun       = overrun;

`ifdef TILE_FETCH_STALL_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (i_line_start) begin
            stall_cnt <= '0;
        end else if ((state == S_WAIT_SPACE) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign o_stall_cycles = stall_cnt;
`else
    assign o_stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_tile_fetch_sequencer.sv
// tb/tb_tile_fetch_sequencer.sv - directed table-driven bench for tile_fetch_sequencer
module tb_tile_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [9:0]  line_y;
    logic [5:0]  scroll_x;
    logic [5:0]  scroll_y;
    logic [5:0]  x_idx;
    logic [5:0]  y_idx;
    logic [7:0]  tex = 8'd0;
    logic        valid;
    logic        ready;
    logic [5:0]  col;
    logic [7:0]  tex_out;
    logic        busy;
    logic        overrun;
    logic [15:0] stall;

    int errors = 0;
    int checks = 0;

`ifdef TILE_FETCH_STALL_STATS_EN
    localparam int STALL_EXP = 14;
`else
    localparam int STALL_EXP = 0;
`endif

    always #5 clk = ~clk;

    // Tilemap model: entry (x,y) = x + 8y, one cycle read latency.
    always @(posedge clk) tex <= 8'(x_idx + 8 * y_idx);

    tile_fetch_sequencer dut (
        .clk                   (clk),
        .reset                 (reset),
        .i_line_start          (line_start),
        .i_line_y              (line_y),
        .i_scroll_x            (scroll_x),
        .i_scroll_y            (scroll_y),
        .o_tilemap_x_idx       (x_idx),
        .o_tilemap_y_idx       (y_idx),
        .i_tilemap_texture_idx (tex),
        .o_tile_valid          (valid),
        .i_tile_ready          (ready),
        .o_tile_col            (col),
        .o_tile_texture_idx    (tex_out),
        .o_busy                (busy),
        .o_overrun             (overrun),
        .o_stall_cycles        (stall)
    );

    typedef struct {
        int ly;
        int sx;
        int sy;
        int erow;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_line(input int ly, input int sx, input int sy);
        line_y     = 10'(ly);
        scroll_x   = 6'(sx);
        scroll_y   = 6'(sy);
        line_start = 1'b1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
    endtask

    task automatic collect_line(input string tag, input int sx, input int erow);
        int ntok     = 0;
        int busy_cyc = 0;
        int first_v  = -1;
        int addr_bad = 0;
        for (int cyc = 0; cyc < 300 && (ntok < 40 || busy); cyc++) begin
            @(negedge clk);
            if (busy) begin
                if (x_idx != 6'((sx + busy_cyc / 2) % 40) || y_idx != 6'(erow)) addr_bad++;
                busy_cyc++;
            end
            if (valid && ready) begin
                if (first_v < 0) first_v = cyc;
                check($sformatf("%s col[%0d]", tag, ntok), col, ntok);
                check($sformatf("%s tex[%0d]", tag, ntok), tex_out, ((sx + ntok) % 40 + 8 * erow) % 256);
                ntok++;
            end
        end
        check($sformatf("%s tokens", tag), ntok, 40);
        check($sformatf("%s first_valid_cycle", tag), first_v, 2);
        check($sformatf("%s busy_cycles", tag), busy_cyc, 80);
        check($sformatf("%s addr_seq_errors", tag), addr_bad, 0);
    endtask

    initial begin
        int hold_bad;
        int ntok;

        vecs[0] = '{0,   0,  0,  0};
        vecs[1] = '{32,  38, 0,  2};
        vecs[2] = '{479, 0,  29, 28};
        vecs[3] = '{100, 5,  10, 16};
        vecs[4] = '{240, 39, 15, 0};

        reset      = 1'b1;
        line_start = 1'b0;
        line_y     = '0;
        scroll_x   = '0;
        scroll_y   = '0;
        ready      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset valid", valid, 0);
        check("reset col", col, 0);
        check("reset tex", tex_out, 0);
        check("reset x", x_idx, 0);
        check("reset y", y_idx, 0);
        check("reset busy", busy, 0);
        check("reset overrun", overrun, 0);
        check("reset stall", stall, 0);
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            start_line(vecs[v].ly, vecs[v].sx, vecs[v].sy);
            collect_line($sformatf("vec%0d", v), vecs[v].sx, vecs[v].erow);
            check($sformatf("vec%0d overrun", v), overrun, 0);
            check($sformatf("vec%0d stall", v), stall, 0);
        end

        // Backpressure: FIFO fills, sequencer parks in WAIT_SPACE on column 8.
        @(negedge clk);
        ready = 1'b0;
        start_line(0, 0, 0);
        hold_bad = 0;
        for (int c = 0; c < 29; c++) begin
            @(negedge clk);
            if (c >= 17 && x_idx != 6'd8) hold_bad++;
        end
        @(negedge clk);
        check("bp valid", valid, 1);
        check("bp busy", busy, 1);
        check("bp head col", col, 0);
        check("bp head tex", tex_out, 0);
        check("bp x held", x_idx, 8);
        check("bp hold errors", hold_bad, 0);
        ready = 1'b1;
        ntok = 0;
        for (int c = 0; c < 300 && (ntok < 40 || busy); c++) begin
            if (valid && ready) begin
                check($sformatf("bp col[%0d]", ntok), col, ntok);
                check($sformatf("bp tex[%0d]", ntok), tex_out, ntok);
                ntok++;
            end
            @(negedge clk);
        end
        check("bp tokens", ntok, 40);
        check("bp stall", stall, STALL_EXP);

        // Overrun: restart at cycle 20 while the FIFO holds old-line tokens.
        @(negedge clk);
        ready = 1'b0;
        start_line(0, 0, 0);
        for (int c = 0; c < 19; c++) @(negedge clk);
        @(negedge clk);
        check("ovr before", overrun, 0);
        check("ovr fifo filled", valid, 1);
        start_line(16, 10, 0);
        ready = 1'b1;
        check("ovr set", overrun, 1);
        check("ovr flushed", valid, 0);
        collect_line("ovr", 10, 1);
        check("ovr sticky", overrun, 1);

        // Reset mid-line at cycle 15.
        @(negedge clk);
        start_line(0, 5, 0);
        for (int c = 0; c < 14; c++) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst valid", valid, 0);
        check("rst col", col, 0);
        check("rst tex", tex_out, 0);
        check("rst x", x_idx, 0);
        check("rst y", y_idx, 0);
        check("rst busy", busy, 0);
        check("rst overrun", overrun, 0);
        check("rst stall", stall, 0);
        start_line(32, 3, 0);
        collect_line("post_rst", 3, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
